// File: rtl/fpu_share_arb.sv
// Shares one multi-cycle FPU between the execution stage (port 0) and a secondary
// issue slot (port 1): round-robin grant, one operation in flight, watchdog abort.
module fpu_share_arb #(
   parameter int TIMEOUT = 64,
   parameter int TW      = 7
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          req0,
   input  logic [3:0]    op0_aluop,
   input  logic [31:0]   op0_a,
   input  logic [31:0]   op0_b,
   input  logic          req1,
   input  logic [3:0]    op1_aluop,
   input  logic [31:0]   op1_a,
   input  logic [31:0]   op1_b,
   output logic          ack0,
   output logic          ack1,
   output logic          done0,
   output logic          done1,
   output logic [31:0]   result,
   output logic          err,
   output logic          busy,
   output logic          fpu_start,
   output logic [3:0]    fpu_aluop,
   output logic [31:0]   fpu_a,
   output logic [31:0]   fpu_b,
   input  logic [31:0]   fpu_result,
   input  logic          fpu_valid,
   output logic [TW-1:0] timeout_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e        state_q, state_d;
   logic          ptr_q, ptr_d;
   logic          owner_q, owner_d;
   logic [3:0]    fpu_aluop_q, fpu_aluop_d;
   logic [31:0]   fpu_a_q, fpu_a_d;
   logic [31:0]   fpu_b_q, fpu_b_d;
   logic [31:0]   result_q, result_d;
   logic          err_q, err_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          grant0, grant1;

   always_comb begin
      // NOTE: every signal takes its default before the case, so no path can infer a latch.
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      fpu_aluop_d = fpu_aluop_q;
      fpu_a_d     = fpu_a_q;
      fpu_b_d     = fpu_b_q;
      result_d    = result_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      grant0      = 1'b0;
      grant1      = 1'b0;

      case (state_q)
         IDLE: begin
            // ptr_q names the requester that wins a tie
            grant0 = req0 && (!req1 || !ptr_q);
            grant1 = req1 && !grant0;
            if (grant0 || grant1) begin
               owner_d     = grant1;
               ptr_d       = grant0;
               fpu_aluop_d = grant1 ? op1_aluop : op0_aluop;
               fpu_a_d     = grant1 ? op1_a     : op0_a;
               fpu_b_d     = grant1 ? op1_b     : op0_b;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + TW'(1);
            if (fpu_valid) begin
               result_d = fpu_result;
               err_d    = 1'b0;
               state_d  = RESP;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         owner_q     <= 1'b0;
         fpu_aluop_q <= '0;
         fpu_a_q     <= '0;
         fpu_b_q     <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         fpu_aluop_q <= fpu_aluop_d;
         fpu_a_q     <= fpu_a_d;
         fpu_b_q     <= fpu_b_d;
         result_q    <= result_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   // Grants are decoded combinationally in IDLE; gating with reset keeps them low while reset is held.
   assign ack0        = grant0 & reset;
   assign ack1        = grant1 & reset;
   assign done0       = (state_q == RESP) && !owner_q;
   assign done1       = (state_q == RESP) &&  owner_q;
   assign busy        = (state_q != IDLE);
   assign fpu_start   = (state_q == ISSUE);
   assign fpu_aluop   = fpu_aluop_q;
   assign fpu_a       = fpu_a_q;
   assign fpu_b       = fpu_b_q;
   assign result      = result_q;
   assign err         = err_q;
   assign timeout_cnt = cnt_q;

endmodule

// File: tb/tb_fpu_share_arb.sv
// Directed bench for fpu_share_arb: a cycle-by-cycle vector table for arbitration and
// normal completion, then hand sequences for timeout, race, reset and busy corner cases.
module tb_fpu_share_arb;

   localparam int TIMEOUT = 8;
   localparam int TW      = 4;

   logic          CLK;
   logic          reset;
   logic          req0, req1;
   logic [3:0]    op0_aluop, op1_aluop;
   logic [31:0]   op0_a, op0_b, op1_a, op1_b;
   logic          ack0, ack1, done0, done1, err, busy, fpu_start;
   logic [31:0]   result;
   logic [3:0]    fpu_aluop;
   logic [31:0]   fpu_a, fpu_b;
   logic [31:0]   fpu_result;
   logic          fpu_valid;
   logic [TW-1:0] timeout_cnt;

   int n_vec  = 0;
   int n_fail = 0;

   fpu_share_arb #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .req0       (req0),
      .op0_aluop  (op0_aluop),
      .op0_a      (op0_a),
      .op0_b      (op0_b),
      .req1       (req1),
      .op1_aluop  (op1_aluop),
      .op1_a      (op1_a),
      .op1_b      (op1_b),
      .ack0       (ack0),
      .ack1       (ack1),
      .done0      (done0),
      .done1      (done1),
      .result     (result),
      .err        (err),
      .busy       (busy),
      .fpu_start  (fpu_start),
      .fpu_aluop  (fpu_aluop),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_result (fpu_result),
      .fpu_valid  (fpu_valid),
      .timeout_cnt(timeout_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // in  = {reset, req0, req1, fpu_valid}
   // exp = {ack0, ack1, fpu_start, done0, done1, busy, err}
   typedef struct packed {
      logic [3:0]  in;
      logic [31:0] fres;
      logic [6:0]  exp;
      logic [31:0] res;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic [3:0] in, input logic [31:0] fres,
                      input logic [6:0] exp, input logic [31:0] res);
      vec_t v;
      v.in = in; v.fres = fres; v.exp = exp; v.res = res;
      tv.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Advance to the next falling edge, where inputs are driven.
   task automatic step();
      @(negedge CLK);
   endtask

   initial begin : main
      string nm [7];
      logic [6:0] act;
      nm = '{"ack0", "ack1", "fpu_start", "done0", "done1", "busy", "err"};

      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; fpu_valid = 1'b0; fpu_result = '0;
      op0_aluop = 4'h0; op0_a = 32'h3F800000; op0_b = 32'h40000000;
      op1_aluop = 4'h3; op1_a = 32'h11111111; op1_b = 32'h22222222;
      #1 reset = 1'b0;

      // Reset, single request with 3-cycle FPU, reset again, then 0/1/0 contention.
      add(4'b0110, 32'h0,        7'b0000000, 32'h0);
      add(4'b1100, 32'h0,        7'b1000000, 32'h0);
      add(4'b1000, 32'h0,        7'b0010010, 32'h0);
      add(4'b1000, 32'h0,        7'b0000010, 32'h0);
      add(4'b1000, 32'h0,        7'b0000010, 32'h0);
      add(4'b1001, 32'h40400000, 7'b0000010, 32'h0);
      add(4'b1000, 32'h0,        7'b0001010, 32'h40400000);
      add(4'b1000, 32'h0,        7'b0000000, 32'h40400000);
      add(4'b0110, 32'h0,        7'b0000000, 32'h0);
      add(4'b1110, 32'h0,        7'b1000000, 32'h0);
      add(4'b1010, 32'h0,        7'b0010010, 32'h0);
      add(4'b1010, 32'h0,        7'b0000010, 32'h0);
      add(4'b1011, 32'hAAAA0001, 7'b0000010, 32'h0);
      add(4'b1010, 32'h0,        7'b0001010, 32'hAAAA0001);
      add(4'b1010, 32'h0,        7'b0100000, 32'hAAAA0001);
      add(4'b1110, 32'h0,        7'b0010010, 32'hAAAA0001);
      add(4'b1111, 32'hBBBB0002, 7'b0000010, 32'hAAAA0001);
      add(4'b1110, 32'h0,        7'b0000110, 32'hBBBB0002);
      add(4'b1110, 32'h0,        7'b1000000, 32'hBBBB0002);
      add(4'b1000, 32'h0,        7'b0010010, 32'hBBBB0002);
      add(4'b1001, 32'hCCCC0003, 7'b0000010, 32'hBBBB0002);
      add(4'b1000, 32'h0,        7'b0001010, 32'hCCCC0003);
      add(4'b1001, 32'hDEAD0000, 7'b0000000, 32'hCCCC0003);
      add(4'b1000, 32'h0,        7'b0000000, 32'hCCCC0003);

      foreach (tv[i]) begin
         step();
         {reset, req0, req1, fpu_valid} = tv[i].in;
         fpu_result = tv[i].fres;
         #2;
         act = {ack0, ack1, fpu_start, done0, done1, busy, err};
         for (int b = 0; b < 7; b++)
            check_bit($sformatf("v%0d %s", i, nm[b]), act[6-b], tv[i].exp[6-b]);
         check($sformatf("v%0d result", i), result, tv[i].res);
      end

      // Timeout on requester 1: done1 ten cycles after ack1, result 0, err 1.
      step(); req1 = 1'b1; op1_aluop = 4'h5; op1_a = 32'h5555AAAA; op1_b = 32'h0F0F0F0F;
      #2 check_bit("to ack1", ack1, 1'b1); check_bit("to ack0", ack0, 1'b0);
      step(); req1 = 1'b0;
      #2 check_bit("to start", fpu_start, 1'b1);
      check("to fpu_a", fpu_a, 32'h5555AAAA);
      check("to fpu_b", fpu_b, 32'h0F0F0F0F);
      check("to fpu_aluop", 32'(fpu_aluop), 32'h5);
      for (int i = 0; i < TIMEOUT; i++) begin
         step();
         #2 check_bit($sformatf("to wait%0d busy", i), busy, 1'b1);
         check_bit($sformatf("to wait%0d done1", i), done1, 1'b0);
         check($sformatf("to wait%0d cnt", i), 32'(timeout_cnt), 32'(i));
      end
      step();
      #2 check_bit("to done1", done1, 1'b1); check_bit("to done0", done0, 1'b0);
      check("to result", result, 32'h0); check_bit("to err", err, 1'b1);
      step();
      #2 check_bit("to busy after", busy, 1'b0); check_bit("to err held", err, 1'b1);

      // fpu_valid in the same cycle the counter reaches TIMEOUT-1: valid wins.
      step(); req0 = 1'b1;
      #2 check_bit("race ack0", ack0, 1'b1);
      step(); req0 = 1'b0;
      #2 check_bit("race start", fpu_start, 1'b1);
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         step();
         #2 check($sformatf("race cnt%0d", i), 32'(timeout_cnt), 32'(i));
      end
      step(); fpu_valid = 1'b1; fpu_result = 32'h12345678;
      #2 check("race cnt last", 32'(timeout_cnt), 32'(TIMEOUT - 1));
      step(); fpu_valid = 1'b0;
      #2 check_bit("race done0", done0, 1'b1); check_bit("race err", err, 1'b0);
      check("race result", result, 32'h12345678);
      step();
      #2 check_bit("race busy after", busy, 1'b0);

      // Reset asserted during WAIT, then a stale fpu_valid, then a normal grant.
      step(); req0 = 1'b1;
      #2 check_bit("rst ack0", ack0, 1'b1);
      step(); req0 = 1'b0;
      #2 check_bit("rst start", fpu_start, 1'b1);
      step();
      step();
      #2 check("rst cnt before", 32'(timeout_cnt), 32'd1);
      #1 reset = 1'b0;
      #1 check_bit("rst busy async", busy, 1'b0);
      check("rst fpu_a async", fpu_a, 32'h0);
      check("rst fpu_b async", fpu_b, 32'h0);
      check("rst result async", result, 32'h0);
      check("rst cnt async", 32'(timeout_cnt), 32'h0);
      check_bit("rst err async", err, 1'b0);
      check_bit("rst done0 async", done0, 1'b0);
      step(); reset = 1'b1; fpu_valid = 1'b1; fpu_result = 32'hBAD0BAD0;
      #2 check_bit("rst stale busy", busy, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(); fpu_valid = 1'b0;
         #2 check_bit($sformatf("rst stale%0d done0", i), done0, 1'b0);
         check_bit($sformatf("rst stale%0d done1", i), done1, 1'b0);
         check($sformatf("rst stale%0d result", i), result, 32'h0);
      end
      step(); req0 = 1'b1; op0_aluop = 4'h2; op0_a = 32'h40A00000; op0_b = 32'h40C00000;
      #2 check_bit("rst regrant ack0", ack0, 1'b1);
      step(); req0 = 1'b0;
      #2 check_bit("rst regrant start", fpu_start, 1'b1);
      check("rst regrant fpu_a", fpu_a, 32'h40A00000);
      step(); fpu_valid = 1'b1; fpu_result = 32'h41300000;
      step(); fpu_valid = 1'b0;
      #2 check_bit("rst regrant done0", done0, 1'b1);
      check("rst regrant result", result, 32'h41300000);
      step();
      #2 check_bit("rst regrant idle", busy, 1'b0);

      // req1 raised while requester 0 waits: ack1 only in the cycle after done0.
      step(); req0 = 1'b1; op0_aluop = 4'h0; op0_a = 32'h3F800000; op0_b = 32'h40000000;
      #2 check_bit("busy ack0", ack0, 1'b1);
      step(); req0 = 1'b0;
      #2 check_bit("busy start", fpu_start, 1'b1);
      step(); req1 = 1'b1; op1_aluop = 4'h7; op1_a = 32'hC0000000; op1_b = 32'h3F000000;
      #2 check_bit("busy w1 ack1", ack1, 1'b0);
      step();
      #2 check_bit("busy w2 ack1", ack1, 1'b0);
      step(); fpu_valid = 1'b1; fpu_result = 32'h40400000;
      #2 check_bit("busy w3 ack1", ack1, 1'b0);
      step(); fpu_valid = 1'b0;
      #2 check_bit("busy done0", done0, 1'b1); check_bit("busy resp ack1", ack1, 1'b0);
      check("busy result0", result, 32'h40400000);
      step();
      #2 check_bit("busy ack1", ack1, 1'b1);
      check("busy fpu_a before", fpu_a, 32'h3F800000);
      step(); req1 = 1'b0;
      #2 check_bit("busy start1", fpu_start, 1'b1);
      check("busy fpu_a1", fpu_a, 32'hC0000000);
      check("busy fpu_b1", fpu_b, 32'h3F000000);
      check("busy fpu_aluop1", 32'(fpu_aluop), 32'h7);
      step(); fpu_valid = 1'b1; fpu_result = 32'hBF800000;
      step(); fpu_valid = 1'b0;
      #2 check_bit("busy done1", done1, 1'b1); check_bit("busy done0 off", done0, 1'b0);
      check("busy result1", result, 32'hBF800000);
      step();
      #2 check_bit("busy idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_share_arb.md
Name: fpu_share_arb

Overview:
- Shares the single multi-cycle FPU between two requesters: port 0 is the execution stage and port 1 is a secondary issue slot.
- Round-robin arbitration with one operation outstanding at a time.
- Captures operands at grant, sequences FPU start and wait, and routes the result back to the owning requester.
- Includes a watchdog that aborts an FPU operation that never completes.

Parameters:
- TIMEOUT, 64: maximum cycles in WAIT before abort (≥2).
- TW, 7: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request; held until ack0.
- op0_aluop  in  4  requester 0 FPU opcode.
- op0_a  in  32  requester 0 operand 1.
- op0_b  in  32  requester 0 operand 2.
- req1  in  1  requester 1 request; held until ack1.
- op1_aluop  in  4  requester 1 FPU opcode.
- op1_a  in  32  requester 1 operand 1.
- op1_b  in  32  requester 1 operand 2.
- ack0  out  1  one-cycle grant pulse to requester 0; operands are captured that cycle.
- ack1  out  1  one-cycle grant pulse to requester 1.
- done0  out  1  one-cycle result-valid pulse to requester 0.
- done1  out  1  one-cycle result-valid pulse to requester 1.
- result  out  32  FPU result, or 0 on timeout; valid while doneN is high.
- err  out  1  high with doneN when the operation timed out.
- busy  out  1  high in any state other than IDLE.
- fpu_start  out  1  one-cycle start pulse to the FPU.
- fpu_aluop  out  4  registered opcode to the FPU.
- fpu_a  out  32  registered operand 1 to the FPU.
- fpu_b  out  32  registered operand 2 to the FPU.
- fpu_result  in  32  FPU result.
- fpu_valid  in  1  FPU completion; one-cycle pulse.
- timeout_cnt  out  TW  current count of WAIT cycles, for debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state = IDLE; priority pointer = 0 (requester 0 favoured).
  - Any in-flight operation is dropped; no done is emitted.
  - A late fpu_valid after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If only one reqN is high, grant it.
  - If both are high, grant the requester selected by the pointer.
  - On grant: ackN=1 for that cycle; latch aluop/a/b into fpu_* regs; record owner; next = ISSUE.
  - Pointer flips to the non-granted requester after every grant.
  - No request: stay in IDLE.
- ISSUE:
  - fpu_start=1 for exactly one cycle; fpu_* held stable.
  - Clear the counter; next = WAIT.
- WAIT:
  - Counter increments each cycle.
  - If fpu_valid=1: latch fpu_result into result; err=0; next = RESP.
  - Else if counter == TIMEOUT-1: result=0; err=1; next = RESP.
  - If fpu_valid and the timeout condition occur in the same cycle, fpu_valid wins (err=0).
- RESP:
  - doneN=1 for the owner only, for one cycle; result and err valid that cycle.
  - Next = IDLE.
  - err and result hold their values until the next RESP.
- fpu_a, fpu_b and fpu_aluop change only on grant.
- fpu_valid outside WAIT is ignored.
- Requests are not acknowledged while busy.
  - A requester that raises req while busy keeps it high and is served after RESP.
  - Minimum grant-to-grant spacing is 4 cycles (grant, ISSUE, ≥1 WAIT, RESP).
- Latency from ack to done = FPU latency + 2 cycles: one ISSUE cycle plus one RESP cycle, with the FPU responding k cycles after fpu_start giving done at ack+k+2.
- A requester must deassert req the cycle after ack unless it has a further operation.
- Dropping req before ack is legal; no grant is issued in that case.

Test Plan:
- Single request: req0 with aluop=4'h0, a=32'h3F800000, b=32'h40000000; FPU returns 32'h40400000 after 3 cycles. Required: ack0 at cycle t, fpu_start at t+1, done0 at t+5 with result=32'h40400000, err=0, done1 never asserted.
- Simultaneous requests after reset: req0 and req1 rise together. Required: ack0 first, then ack1 only after done0; a third back-to-back contention round grants requester 0 again (alternation 0,1,0).
- Timeout: TIMEOUT=8, FPU never asserts fpu_valid. Required: done1 exactly 10 cycles after ack1 (1 ISSUE + 8 WAIT + 1 RESP) with result=0, err=1; busy drops the following cycle.
- Race: fpu_valid arrives in the same cycle the counter reaches TIMEOUT-1. Required: err=0 and result = fpu_result.
- Reset mid-operation: assert reset in WAIT. Required: outputs 0 immediately, without waiting for a clock edge; a stale fpu_valid after release produces no done; the next req0 is granted normally.
- Request while busy: req1 raised during WAIT for requester 0. Required: no ack1 until the cycle after done0, then ack1 and correct operands on fpu_a and fpu_b.
